// File: rtl/inst_mem_loader.sv
// Instruction memory loader: parses a length/data/checksum byte stream and writes
// little-endian 32-bit words into instruction memory while holding the core.
module inst_mem_loader #(
    parameter int DEPTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_loaded
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN0 = 3'd1;
    localparam logic [2:0] S_LEN1 = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CSUM = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [2:0]       state;
    logic [CNT_W-1:0] len;
    logic [7:0]       len_lo;
    logic [1:0]       byte_idx;
    logic [7:0]       csum;
    logic [23:0]      word_p0;

    function automatic logic [31:0] word_addr(input logic [CNT_W-1:0] idx);
        return 32'({idx, 2'b00});
    endfunction

    assign busy       = (state == S_LEN0) || (state == S_LEN1) ||
                        (state == S_DATA) || (state == S_CSUM);
    assign byte_ready = busy;
    assign done       = (state == S_DONE);
    assign error      = (state == S_ERR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            len          <= '0;
            byte_idx     <= 2'd0;
            csum         <= 8'd0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            cpu_hold     <= 1'b0;
            words_loaded <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state        <= S_LEN0;
                        cpu_hold     <= 1'b1;
                        words_loaded <= '0;
                        csum         <= 8'd0;
                        byte_idx     <= 2'd0;
                    end
                end
                S_LEN0: begin
                    if (byte_valid) state <= S_LEN1;
                end
                S_LEN1: begin
                    if (byte_valid) begin
                        len <= CNT_W'({byte_data, len_lo});
                        if ({byte_data, len_lo} > 16'(DEPTH))
                            state <= S_ERR;
                        else if ({byte_data, len_lo} == 16'd0)
                            state <= S_CSUM;
                        else
                            state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (byte_valid) begin
                        csum     <= csum ^ byte_data;
                        byte_idx <= byte_idx + 2'd1;
                        // Fourth lane completes the word: write it while the next word streams in
                        if (byte_idx == 2'd3) begin
                            mem_we       <= 1'b1;
                            mem_addr     <= word_addr(words_loaded);
                            mem_wdata    <= {byte_data, word_p0};
                            words_loaded <= words_loaded + ONE;
                            if (words_loaded == len - ONE) state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (byte_valid) begin
                        if (byte_data == csum) begin
                            state    <= S_DONE;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERR;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Header low byte and the lower three lanes of the word under assembly
    always_ff @(posedge clk) begin
        if (state == S_LEN0 && byte_valid) len_lo <= byte_data;
        if (state == S_DATA && byte_valid) begin
            case (byte_idx)
                2'd0:    word_p0[7:0]   <= byte_data;
                2'd1:    word_p0[15:8]  <= byte_data;
                2'd2:    word_p0[23:16] <= byte_data;
                default: ;
            endcase
        end
    end

endmodule
